dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: big-endian byte store behind a
// valid/ready request/response handshake with fixed latency.
module dmem_responder #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int LAT   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_write,
  output logic [31:0]   resp_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          resp_valid_q;
  logic          resp_write_q;
  logic [31:0]   rdata_q;
  logic [7:0]    mem_q [DEPTH];

  // Byte lanes of the captured word; AW-bit adds wrap modulo DEPTH.
  logic [AW-1:0] a0_d;
  logic [AW-1:0] a1_d;
  logic [AW-1:0] a2_d;
  logic [AW-1:0] a3_d;
  logic [31:0]   rword_d;

  assign a0_d = addr_q;
  assign a1_d = addr_q + AW'(1);
  assign a2_d = addr_q + AW'(2);
  assign a3_d = addr_q + AW'(3);

  assign rword_d = {mem_q[a0_d], mem_q[a1_d],
                    mem_q[a2_d], mem_q[a3_d]};

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign resp_rdata = rdata_q;

  // Transaction FSM, memory array and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      rdata_q      <= 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (wr_q) begin
              mem_q[a0_d] <= wdata_q[31:24];
              mem_q[a1_d] <= wdata_q[23:16];
              mem_q[a2_d] <= wdata_q[15:8];
              mem_q[a3_d] <= wdata_q[7:0];
              rdata_q     <= 32'h0;
            end else begin
              rdata_q <= rword_d;
            end
            resp_write_q <= wr_q;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference
// model, random traffic, latency/backpressure/reset checks.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_write;
  logic [31:0] resp_rdata;

  logic        rv1;
  logic        rr1;
  logic        rw1_o;
  logic        rvo1;
  logic        rdy1;
  logic [31:0] rd1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(32), .AW(5), .LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_write (resp_write),
    .resp_rdata (resp_rdata)
  );

  dmem_responder #(.DEPTH(32), .AW(5), .LAT(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (rv1),
    .req_ready  (rdy1),
    .req_write  (1'b0),
    .req_addr   (5'd3),
    .req_wdata  (32'h0),
    .resp_valid (rvo1),
    .resp_ready (rr1),
    .resp_write (rw1_o),
    .resp_rdata (rd1)
  );

  typedef struct {
    logic        w;
    logic [31:0] d;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          acc_q[$];
  int          acc1_q[$];
  logic [7:0]  ref_mem [32];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        prev_v = 1'b0;
  logic [31:0] held_d;
  logic        held_w;
  logic [31:0] last_d;
  logic        last_w;
  logic        rr_mode = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rr_mode) begin
      #1 resp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Request side: the model applies each accepted request to a
  // plain byte array and queues the response it must produce.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
      sb_q.delete();
    end else if (req_valid && req_ready) begin
      e.w   = req_write;
      e.acc = cyc + 1;
      e.d   = 32'h0;
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (int'(req_addr) + k) % 32;
        if (req_write) ref_mem[idx] = req_wdata[31-8*k -: 8];
        else           e.d[31-8*k -: 8] = ref_mem[idx];
      end
      sb_q.push_back(e);
      acc_q.push_back(cyc + 1);
    end
    if (!reset && rv1 && rdy1) acc1_q.push_back(cyc + 1);
  end

  // Response side: pop and compare on each new response, then
  // require the response to stay frozen while it is held.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && resp_valid && !prev_v) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got valid=1, want none (cyc %0d)",
                 cyc);
      end else begin
        e = sb_q.pop_front();
        chk("latency", 32'(cyc - e.acc), 32'(LAT));
        chk("resp_write", {31'b0, resp_write}, {31'b0, e.w});
        chk("resp_rdata", resp_rdata, e.d);
      end
      held_d = resp_rdata;
      held_w = resp_write;
      last_d = resp_rdata;
      last_w = resp_write;
    end else if (!reset && resp_valid && prev_v) begin
      chk("hold_rdata", resp_rdata, held_d);
      chk("hold_write", {31'b0, resp_write}, {31'b0, held_w});
      chk("ready_in_resp", {31'b0, req_ready}, 32'h0);
    end
    prev_v = reset ? 1'b0 : resp_valid;
  end

  task automatic wait_idle(string nm);
    int t;
    t = 0;
    while (!req_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got req_ready=0, want 1", nm);
    end
  endtask

  task automatic issue(logic w, logic [4:0] a, logic [31:0] d);
    wait_idle("issue");
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic txn(logic w, logic [4:0] a, logic [31:0] d);
    issue(w, a, d);
    wait_idle("done");
  endtask

  initial begin
    int t;
    int b0;
    int b1;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    rv1        = 1'b0;
    rr1        = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_write", {31'b0, resp_write}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);

    txn(1'b0, 5'd0, 32'h0);
    chk("t1_rdata", last_d, 32'h0);
    chk("t1_write", {31'b0, last_w}, 32'h0);

    txn(1'b1, 5'd8, 32'hDEADBEEF);
    chk("t2_wr_write", {31'b0, last_w}, 32'h1);
    chk("t2_wr_rdata", last_d, 32'h0);
    txn(1'b0, 5'd8, 32'h0);
    chk("t2_rd8", last_d, 32'hDEADBEEF);
    txn(1'b0, 5'd9, 32'h0);
    chk("t2_rd9", last_d, 32'hADBEEF00);

    txn(1'b1, 5'd30, 32'h11223344);
    txn(1'b0, 5'd0, 32'h0);
    chk("t3_rd0", last_d, 32'h33440000);
    txn(1'b0, 5'd29, 32'h0);
    chk("t3_rd29", last_d, 32'h00112233);

    resp_ready = 1'b0;
    issue(1'b0, 5'd8, 32'h0);
    t = 0;
    while (!resp_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", {31'b0, resp_valid}, 32'h1);
      chk("t4_rdata", resp_rdata, 32'hDEADBEEF);
      chk("t4_req_ready", {31'b0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_valid_drop", {31'b0, resp_valid}, 32'h0);
    chk("t4_ready_back", {31'b0, req_ready}, 32'h1);

    issue(1'b1, 5'd4, 32'hCAFEF00D);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      chk("t5_no_resp", {31'b0, resp_valid}, 32'h0);
      @(posedge clk); #1;
    end
    txn(1'b0, 5'd4, 32'h0);
    chk("t5_rd4", last_d, 32'h0);

    b0 = acc_q.size();
    b1 = acc1_q.size();
    req_write = 1'b0;
    req_addr  = 5'd2;
    req_valid = 1'b1;
    rv1       = 1'b1;
    t = 0;
    while ((acc_q.size() < b0 + 3 || acc1_q.size() < b1 + 3) && t < 60) begin
      @(posedge clk); #1;
      if (acc_q.size() >= b0 + 3) req_valid = 1'b0;
      if (acc1_q.size() >= b1 + 3) rv1 = 1'b0;
      t++;
    end
    req_valid = 1'b0;
    rv1       = 1'b0;
    if (acc_q.size() >= b0 + 3 && acc1_q.size() >= b1 + 3) begin
      chk("t6_gap_a", 32'(acc_q[b0+1] - acc_q[b0]), 32'd4);
      chk("t6_gap_b", 32'(acc_q[b0+2] - acc_q[b0+1]), 32'd4);
      chk("t6_lat1_a", 32'(acc1_q[b1+1] - acc1_q[b1]), 32'd3);
      chk("t6_lat1_b", 32'(acc1_q[b1+2] - acc1_q[b1+1]), 32'd3);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL t6_accepts: got %0d/%0d, want 3/3",
               acc_q.size() - b0, acc1_q.size() - b1);
    end
    wait_idle("t6");

    rr_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom);
    end
    wait_idle("rand");
    rr_mode = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
